vga_timing_tx: RTL and testbench

VGA_TIMING_TX -- requirements
Module: vga_timing_tx

---
 rtl/vga_timing_tx.sv | 115 +++++++++++
 tb/tb_vga_timing_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_tx.sv
// vga_timing_tx: VGA raster timing with a two-stage pixel pipeline, colour bars and frame counting
module vga_timing_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_25,
  input  logic        Reset,
  input  logic        PatternSel,
  input  logic [23:0] PixelData,
  output logic        PixelReq,
  output logic [9:0]  PixelX,
  output logic [9:0]  PixelY,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        FrameStart,
  output logic [15:0] FrameCount
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_h, r_v, r_x1;
  logic        r_act1, r_hs1, r_vs1, r_sel1, r_fs1;
  logic        r_hs, r_vs, r_blank_n, r_fs;
  logic [23:0] r_rgb;
  logic [15:0] r_fc;
  logic        w_h_last, w_v_last, w_hs_n, w_vs_n;
  logic [9:0]  w_bar_full;
  logic [2:0]  w_bar;
  logic [23:0] w_bars, w_colour;

  assign w_h_last    = r_h == H_LAST;
  assign w_v_last    = r_v == V_LAST;
  assign w_hs_n      = !(r_h >= HS_ON && r_h < HS_OFF);
  assign w_vs_n      = !(r_v >= VS_ON && r_v < VS_OFF);
  assign PixelX      = r_h;
  assign PixelY      = r_v;
  assign PixelReq    = (r_h < H_ACT) && (r_v < V_ACT);
  assign VGA_CLK     = CLOCK_25;
  assign w_bar_full  = r_x1 / 10'd80;
  assign w_bar       = w_bar_full[2:0];
  assign w_bars      = {{8{~w_bar[0]}}, {8{~w_bar[2]}}, {8{~w_bar[1]}}};
  assign w_colour    = r_sel1 ? w_bars : PixelData;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign {VGA_B, VGA_G, VGA_R} = r_rgb;
  assign FrameStart  = r_fs;
  assign FrameCount  = r_fc;

  // Raster counters: h sweeps each line, v advances on every h wrap
  always_ff @(posedge CLOCK_25) begin
    if (Reset) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 10'd1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 10'd1;
    end
  end

  // Stage 1: timing decoded from the counters, aligned with the upstream pixel data
  always_ff @(posedge CLOCK_25) begin
    if (Reset) begin
      r_act1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_sel1 <= 1'b0;
      r_fs1  <= 1'b0;
      r_x1   <= '0;
    end else begin
      r_act1 <= PixelReq;
      r_hs1  <= w_hs_n;
      r_vs1  <= w_vs_n;
      r_sel1 <= PatternSel;
      r_fs1  <= (r_h == '0) && (r_v == '0);
      r_x1   <= r_h;
    end
  end

  // Stage 2: output pins, colour forced to black outside the visible area
  always_ff @(posedge CLOCK_25) begin
    if (Reset) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
      r_fs      <= 1'b0;
      r_fc      <= '0;
    end else begin
      r_hs      <= r_hs1;
      r_vs      <= r_vs1;
      r_blank_n <= r_act1;
      r_rgb     <= r_act1 ? w_colour : '0;
      r_fs      <= r_fs1;
      r_fc      <= r_fc + 16'(r_fs1);
    end
  end
endmodule

// File: tb/tb_vga_timing_tx.sv
// tb_vga_timing_tx: directed bench on a shortened 800x8 raster (640 visible columns, 4 visible lines)
module tb_vga_timing_tx;
  logic        CLOCK_25 = 1'b0;
  logic        Reset, PatternSel;
  logic [23:0] PixelData, pend;
  logic        PixelReq, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, FrameStart;
  logic [9:0]  PixelX, PixelY;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [15:0] FrameCount;
  logic [23:0] rgb, yel, grn, blu, pix53;
  int n_chk = 0, n_fail = 0, clk_bad = 0;
  int t, hh, vv, brun, hrun, vrun, bruns, hruns, vruns, offs, last_bfall, last_fs, fs_cnt;
  int bad_b, bad_h, bad_v, bad_off, bad_fsw, bad_fsp, bad_act, bad_blk, bad_dat, bad_wht, bad_k;
  logic act, p_blank, p_hs, p_vs, p_fs, found;

  vga_timing_tx #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
    .CLOCK_25(CLOCK_25), .Reset(Reset), .PatternSel(PatternSel), .PixelData(PixelData),
    .PixelReq(PixelReq), .PixelX(PixelX), .PixelY(PixelY), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .FrameStart(FrameStart), .FrameCount(FrameCount)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  assign rgb = {VGA_B, VGA_G, VGA_R};

  // Synchronous-ROM stand-in: data for the coordinate requested in one cycle appears in the next
  always @(negedge CLOCK_25) pend = {PixelY[7:0], PixelX[7:0], 8'hA5};
  always @(posedge CLOCK_25) begin
    #1;
    PixelData = pend;
    if (VGA_CLK !== 1'b1) clk_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; PatternSel = 1'b0; PixelData = '0;
    {brun, hrun, vrun, bruns, hruns, vruns, offs, fs_cnt} = '0;
    {bad_b, bad_h, bad_v, bad_off, bad_fsw, bad_fsp, bad_act, bad_blk, bad_dat, bad_wht, bad_k} = '0;
    last_bfall = -10000; last_fs = 0;
    p_blank = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
    yel = '0; grn = '0; blu = '0; pix53 = '0;
    @(negedge CLOCK_25);
    check("rst_hs", VGA_HS, 1);
    check("rst_vs", VGA_VS, 1);
    check("rst_blank_n", VGA_BLANK_N, 0);
    check("rst_rgb", rgb, 0);
    check("rst_fs", FrameStart, 0);
    check("rst_fc", FrameCount, 0);
    check("rst_req", PixelReq, 1);
    check("rst_xy", {PixelX, PixelY}, 0);
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    Reset = 1'b0;
    for (int n = 1; n <= 19000; n++) begin
      @(negedge CLOCK_25);
      if (VGA_CLK !== CLOCK_25) clk_bad++;
      if (VGA_BLANK_N) brun++;
      if (!VGA_BLANK_N && p_blank) begin
        bruns++;
        if (brun != 640) bad_b++;
        brun = 0;
        last_bfall = n;
      end
      if (!VGA_HS) hrun++;
      if (!VGA_HS && p_hs && n - last_bfall < 800) begin
        offs++;
        if (n - last_bfall != 16) bad_off++;
      end
      if (VGA_HS && !p_hs) begin
        hruns++;
        if (hrun != 96) bad_h++;
        hrun = 0;
      end
      if (!VGA_VS) vrun++;
      if (VGA_VS && !p_vs) begin
        vruns++;
        if (vrun != 1600) bad_v++;
        vrun = 0;
      end
      if (FrameStart) begin
        fs_cnt++;
        if (p_fs) bad_fsw++;
        if (fs_cnt > 1 && n - last_fs != 6400) bad_fsp++;
        last_fs = n;
      end
      t = n - 2;
      if (t >= 0) begin
        hh = t % 800;
        vv = (t / 800) % 8;
        act = hh < 640 && vv < 4;
        if (VGA_BLANK_N !== act) bad_act++;
        if (!VGA_BLANK_N && rgb !== 24'h0) bad_blk++;
        if (act && n < 10000 && rgb !== {8'(vv), 8'(hh), 8'hA5}) bad_dat++;
      end
      if (n >= 12802 && n <= 12881 && rgb !== 24'hFFFFFF) bad_wht++;
      if (n >= 13362 && n <= 13441 && rgb !== 24'h0) bad_k++;
      if (n == 2407) pix53 = rgb;
      if (n == 12882) yel = rgb;
      if (n == 13042) grn = rgb;
      if (n == 13282) blu = rgb;
      if (n == 10000) PatternSel = 1'b1;
      p_blank = VGA_BLANK_N; p_hs = VGA_HS; p_vs = VGA_VS; p_fs = FrameStart;
    end
    check("pix53_r", pix53[7:0], 8'hA5);
    check("pix53_g", pix53[15:8], 8'h05);
    check("pix53_b", pix53[23:16], 8'h03);
    check("blank_lines", bruns, 12);
    check("blank_len", bad_b, 0);
    check("hs_pulses", hruns, 23);
    check("hs_len", bad_h, 0);
    check("hs_offs_n", offs, 12);
    check("hs_offset", bad_off, 0);
    check("vs_pulses", vruns, 3);
    check("vs_len", bad_v, 0);
    check("fs_count", fs_cnt, 3);
    check("fs_width", bad_fsw, 0);
    check("fs_period", bad_fsp, 0);
    check("frame_count", FrameCount, 3);
    check("blank_align", bad_act, 0);
    check("blank_rgb0", bad_blk, 0);
    check("pixel_data", bad_dat, 0);
    check("bar_white", bad_wht, 0);
    check("bar_yellow", yel, 24'h00FFFF);
    check("bar_green", grn, 24'h00FF00);
    check("bar_blue", blu, 24'hFF0000);
    check("bar_black", bad_k, 0);
    found = 1'b0;
    for (int i = 0; i < 7000 && !found; i++) begin
      @(negedge CLOCK_25);
      found = PixelX == 10'd300 && PixelY == 10'd2;
    end
    check("mid_found", found, 1);
    Reset = 1'b1;
    @(negedge CLOCK_25);
    check("mr_hs", VGA_HS, 1);
    check("mr_vs", VGA_VS, 1);
    check("mr_blank_n", VGA_BLANK_N, 0);
    check("mr_rgb", rgb, 0);
    check("mr_fs", FrameStart, 0);
    check("mr_fc", FrameCount, 0);
    check("mr_xy", {PixelX, PixelY}, 0);
    check("mr_req", PixelReq, 1);
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    Reset = 1'b0;
    @(negedge CLOCK_25);
    check("rel1_fs", FrameStart, 0);
    check("rel1_fc", FrameCount, 0);
    @(negedge CLOCK_25);
    check("rel2_fs", FrameStart, 1);
    check("rel2_fc", FrameCount, 1);
    check("rel2_blank_n", VGA_BLANK_N, 1);
    check("rel2_rgb", rgb, 24'hFFFFFF);
    @(negedge CLOCK_25);
    check("rel3_fs", FrameStart, 0);
    check("vga_clk", clk_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
